pipe_bypass_chain: RTL and testbench

Parametrised in-order pipeline register chain with per-stage valid tracking, stall and kill control, late result capture, and an N-port register-forwarding lookup. It generalises the fixed E/M/W pipeline registers, flush signals and forwarding muxes of the 5-stage core into one reusable block. The block sits between decode/issue and register-file writeback. Hazard logic consumes its forwarding outputs instead of hand-wired per-stage comparators.

---
 rtl/pipe_bypass_chain.sv | 168 ++++++++++++++++
 tb/tb_pipe_bypass_chain.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/pipe_bypass_chain.sv
// In-order pipeline register chain with stall/kill, late result
// capture and multi-port register forwarding lookup.
module pipe_bypass_chain #(
  parameter int DW        = 32,
  parameter int AW        = 5,
  parameter int NSTAGE    = 3,
  parameter int NSRC      = 2,
  parameter int RES_STAGE = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DW-1:0]        in_data,
  input  logic                 in_wen,
  input  logic [AW-1:0]        in_waddr,
  input  logic                 in_wdv,
  input  logic [DW-1:0]        in_wdata,
  input  logic [NSTAGE-1:0]    stall,
  input  logic [NSTAGE-1:0]    kill,
  input  logic                 res_en,
  input  logic [DW-1:0]        res_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DW-1:0]        out_data,
  output logic [DW-1:0]        out_wdata,
  output logic                 out_wen,
  output logic [AW-1:0]        out_waddr,
  output logic                 out_wdv,
  output logic [NSTAGE-1:0]    stage_valid,
  input  logic [NSRC*AW-1:0]   src_addr,
  output logic [NSRC-1:0]      fwd_hit,
  output logic [NSRC-1:0]      fwd_pend,
  output logic [NSRC*DW-1:0]   fwd_data
);

  logic [NSTAGE-1:0] valid_q, valid_d;
  logic [NSTAGE-1:0] wen_q, wen_d;
  logic [NSTAGE-1:0] wdv_q, wdv_d;
  logic [DW-1:0]     data_q  [NSTAGE];
  logic [DW-1:0]     data_d  [NSTAGE];
  logic [DW-1:0]     wdata_q [NSTAGE];
  logic [DW-1:0]     wdata_d [NSTAGE];
  logic [AW-1:0]     waddr_q [NSTAGE];
  logic [AW-1:0]     waddr_d [NSTAGE];

  logic [NSTAGE:0]   room;
  logic [NSTAGE-1:0] adv;
  logic              cap;
  logic              accept;
  logic [NSTAGE-1:0] wdv_e;
  logic [DW-1:0]     wdata_e [NSTAGE];

  // Advance chain, resolved from the oldest stage back to issue.
  // A killed stage counts as free for the stage behind it.
  always_comb begin
    room = '0;
    adv  = '0;
    room[NSTAGE] = out_ready;
    for (int i = NSTAGE-1; i >= 0; i--) begin
      adv[i]  = valid_q[i] & ~stall[i] & ~kill[i] & room[i+1];
      room[i] = ~valid_q[i] | adv[i] | kill[i];
    end
  end

  assign in_ready = ~rst & room[0];
  assign accept   = in_valid & in_ready;

  // Late result merged into an effective view of the stage fields,
  // shared by the next-state logic and the forwarding lookup.
  always_comb begin
    cap = res_en & valid_q[RES_STAGE] & wen_q[RES_STAGE]
        & ~wdv_q[RES_STAGE] & ~kill[RES_STAGE];
    wdv_e   = wdv_q;
    wdata_e = wdata_q;
    if (cap) begin
      wdv_e[RES_STAGE]   = 1'b1;
      wdata_e[RES_STAGE] = res_data;
    end
  end

  // Next stage contents: load from upstream, bubble, or hold.
  always_comb begin
    valid_d = valid_q;
    wen_d   = wen_q;
    wdv_d   = wdv_e;
    data_d  = data_q;
    wdata_d = wdata_e;
    waddr_d = waddr_q;
    if (accept) begin
      valid_d[0] = 1'b1;
      data_d[0]  = in_data;
      wen_d[0]   = in_wen;
      waddr_d[0] = in_waddr;
      wdv_d[0]   = in_wdv;
      wdata_d[0] = in_wdata;
    end else if (adv[0] | kill[0]) begin
      valid_d[0] = 1'b0;
    end
    for (int i = 1; i < NSTAGE; i++) begin
      if (adv[i-1]) begin
        valid_d[i] = 1'b1;
        data_d[i]  = data_q[i-1];
        wen_d[i]   = wen_q[i-1];
        waddr_d[i] = waddr_q[i-1];
        wdv_d[i]   = wdv_e[i-1];
        wdata_d[i] = wdata_e[i-1];
      end else if (adv[i] | kill[i]) begin
        valid_d[i] = 1'b0;
      end
    end
  end

  // Stage state registers with synchronous clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      wen_q   <= '0;
      wdv_q   <= '0;
      for (int i = 0; i < NSTAGE; i++) begin
        data_q[i]  <= '0;
        wdata_q[i] <= '0;
        waddr_q[i] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      wen_q   <= wen_d;
      wdv_q   <= wdv_d;
      for (int i = 0; i < NSTAGE; i++) begin
        data_q[i]  <= data_d[i];
        wdata_q[i] <= wdata_d[i];
        waddr_q[i] <= waddr_d[i];
      end
    end
  end

  // Forwarding: youngest live writer wins, even if still pending.
  always_comb begin
    fwd_hit  = '0;
    fwd_pend = '0;
    fwd_data = '0;
    for (int j = 0; j < NSRC; j++) begin
      for (int i = NSTAGE-1; i >= 0; i--) begin
        if (valid_q[i] & wen_q[i] & ~kill[i]
            & (waddr_q[i] == src_addr[j*AW +: AW])
            & (src_addr[j*AW +: AW] != '0)) begin
          fwd_hit[j] = 1'b1;
          if (wdv_e[i]) begin
            fwd_pend[j]          = 1'b0;
            fwd_data[j*DW +: DW] = wdata_e[i];
          end else begin
            fwd_pend[j]          = 1'b1;
            fwd_data[j*DW +: DW] = '0;
          end
        end
      end
    end
  end

  assign out_valid   = valid_q[NSTAGE-1] & ~rst;
  assign out_data    = data_q[NSTAGE-1];
  assign out_wdata   = wdata_q[NSTAGE-1];
  assign out_wen     = out_valid & wen_q[NSTAGE-1];
  assign out_waddr   = waddr_q[NSTAGE-1];
  assign out_wdv     = wdv_q[NSTAGE-1];
  assign stage_valid = valid_q;

endmodule

// File: tb/tb_pipe_bypass_chain.sv
// Directed table-driven bench for pipe_bypass_chain (NSTAGE=3,
// RES_STAGE=1) plus hand sequences for r0, port 1 and reset.
module tb_pipe_bypass_chain;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NS = 3;
  localparam int NSRC = 2;

  logic clk = 1'b0;
  logic rst;
  logic in_valid, in_ready;
  logic [DW-1:0] in_data, in_wdata;
  logic in_wen, in_wdv;
  logic [AW-1:0] in_waddr;
  logic [NS-1:0] stall, kill;
  logic res_en;
  logic [DW-1:0] res_data;
  logic out_valid, out_ready;
  logic [DW-1:0] out_data, out_wdata;
  logic out_wen, out_wdv;
  logic [AW-1:0] out_waddr;
  logic [NS-1:0] stage_valid;
  logic [NSRC*AW-1:0] src_addr;
  logic [NSRC-1:0] fwd_hit, fwd_pend;
  logic [NSRC*DW-1:0] fwd_data;

  int nchk = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  pipe_bypass_chain #(
    .DW(DW), .AW(AW), .NSTAGE(NS),
    .NSRC(NSRC), .RES_STAGE(1)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_wen(in_wen),
    .in_waddr(in_waddr), .in_wdv(in_wdv),
    .in_wdata(in_wdata), .stall(stall),
    .kill(kill), .res_en(res_en),
    .res_data(res_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data),
    .out_wdata(out_wdata), .out_wen(out_wen),
    .out_waddr(out_waddr), .out_wdv(out_wdv),
    .stage_valid(stage_valid),
    .src_addr(src_addr), .fwd_hit(fwd_hit),
    .fwd_pend(fwd_pend), .fwd_data(fwd_data)
  );

  typedef struct {
    logic [31:0] iv, id, wen, wa, wdv, wd;
    logic [31:0] st, kl, ordy, ren, rd, s0, s1;
    logic [31:0] e_ir, e_sv, e_ov, e_od;
    logic [31:0] e_hit, e_pend, e_fd, cw, e_wd;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input vec_t v);
    tbl.push_back(v);
  endtask

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    in_valid  = v.iv[0];
    in_data   = v.id;
    in_wen    = v.wen[0];
    in_waddr  = v.wa[AW-1:0];
    in_wdv    = v.wdv[0];
    in_wdata  = v.wd;
    stall     = v.st[NS-1:0];
    kill      = v.kl[NS-1:0];
    out_ready = v.ordy[0];
    res_en    = v.ren[0];
    res_data  = v.rd;
    src_addr  = {v.s1[AW-1:0], v.s0[AW-1:0]};
  endtask

  task automatic check(input vec_t v, input int n);
    chk($sformatf("r%0d in_ready", n), 32'(in_ready), v.e_ir);
    chk($sformatf("r%0d stage_valid", n), 32'(stage_valid), v.e_sv);
    chk($sformatf("r%0d out_valid", n), 32'(out_valid), v.e_ov);
    if (v.e_ov[0])
      chk($sformatf("r%0d out_data", n), out_data, v.e_od);
    chk($sformatf("r%0d fwd_hit", n), 32'(fwd_hit), v.e_hit);
    chk($sformatf("r%0d fwd_pend", n), 32'(fwd_pend), v.e_pend);
    chk($sformatf("r%0d fwd_data0", n), fwd_data[31:0], v.e_fd);
    if (v.cw[0]) begin
      chk($sformatf("r%0d out_wdata", n), out_wdata, v.e_wd);
      chk($sformatf("r%0d out_wdv", n), 32'(out_wdv), 1);
      chk($sformatf("r%0d out_wen", n), 32'(out_wen), 1);
    end
  endtask

  initial begin
    // iv,id,wen,wa,wdv,wd,st,kl,ordy,ren,rd,s0,s1,
    // ir,sv,ov,od,hit,pend,fd0,cw,wd
    // stream 1..4 at full throughput
    add('{1,1,0,0,0,0,0,0,1,0,0,0,0, 1,'b000,0,0, 0,0,0,0,0});
    add('{1,2,0,0,0,0,0,0,1,0,0,0,0, 1,'b001,0,0, 0,0,0,0,0});
    add('{1,3,0,0,0,0,0,0,1,0,0,0,0, 1,'b011,0,0, 0,0,0,0,0});
    add('{1,4,0,0,0,0,0,0,1,0,0,0,0, 1,'b111,1,1, 0,0,0,0,0});
    add('{0,0,0,0,0,0,0,0,1,0,0,0,0, 1,'b111,1,2, 0,0,0,0,0});
    add('{0,0,0,0,0,0,0,0,1,0,0,0,0, 1,'b110,1,3, 0,0,0,0,0});
    add('{0,0,0,0,0,0,0,0,1,0,0,0,0, 1,'b100,1,4, 0,0,0,0,0});
    add('{0,0,0,0,0,0,0,0,1,0,0,0,0, 1,'b000,0,0, 0,0,0,0,0});
    // fill with out_ready=0, then accept+retire in one cycle
    add('{1,'h11,0,0,0,0,0,0,0,0,0,0,0, 1,'b000,0,0, 0,0,0,0,0});
    add('{1,'h12,0,0,0,0,0,0,0,0,0,0,0, 1,'b001,0,0, 0,0,0,0,0});
    add('{1,'h13,0,0,0,0,0,0,0,0,0,0,0, 1,'b011,0,0, 0,0,0,0,0});
    add('{1,'h14,0,0,0,0,0,0,0,0,0,0,0, 0,'b111,1,'h11, 0,0,0,0,0});
    add('{1,'h14,0,0,0,0,0,0,0,0,0,0,0, 0,'b111,1,'h11, 0,0,0,0,0});
    add('{1,'h14,0,0,0,0,0,0,1,0,0,0,0, 1,'b111,1,'h11, 0,0,0,0,0});
    add('{0,0,0,0,0,0,0,0,0,0,0,0,0, 0,'b111,1,'h12, 0,0,0,0,0});
    add('{0,0,0,0,0,0,0,0,1,0,0,0,0, 1,'b111,1,'h12, 0,0,0,0,0});
    add('{0,0,0,0,0,0,0,0,1,0,0,0,0, 1,'b110,1,'h13, 0,0,0,0,0});
    add('{0,0,0,0,0,0,0,0,1,0,0,0,0, 1,'b100,1,'h14, 0,0,0,0,0});
    add('{0,0,0,0,0,0,0,0,1,0,0,0,0, 1,'b000,0,0, 0,0,0,0,0});
    // stall[1] for two cycles mid-stream
    add('{1,'h21,0,0,0,0,0,0,1,0,0,0,0, 1,'b000,0,0, 0,0,0,0,0});
    add('{1,'h22,0,0,0,0,0,0,1,0,0,0,0, 1,'b001,0,0, 0,0,0,0,0});
    add('{1,'h23,0,0,0,0,0,0,1,0,0,0,0, 1,'b011,0,0, 0,0,0,0,0});
    add('{1,'h24,0,0,0,0,'b010,0,1,0,0,0,0, 0,'b111,1,'h21, 0,0,0,0,0});
    add('{1,'h24,0,0,0,0,'b010,0,1,0,0,0,0, 0,'b011,0,0, 0,0,0,0,0});
    add('{1,'h24,0,0,0,0,0,0,1,0,0,0,0, 1,'b011,0,0, 0,0,0,0,0});
    add('{0,0,0,0,0,0,0,0,1,0,0,0,0, 1,'b111,1,'h22, 0,0,0,0,0});
    add('{0,0,0,0,0,0,0,0,1,0,0,0,0, 1,'b110,1,'h23, 0,0,0,0,0});
    add('{0,0,0,0,0,0,0,0,1,0,0,0,0, 1,'b100,1,'h24, 0,0,0,0,0});
    add('{0,0,0,0,0,0,0,0,1,0,0,0,0, 1,'b000,0,0, 0,0,0,0,0});
    // kill=011 with all stages full
    add('{1,'h31,0,0,0,0,0,0,1,0,0,0,0, 1,'b000,0,0, 0,0,0,0,0});
    add('{1,'h32,0,0,0,0,0,0,1,0,0,0,0, 1,'b001,0,0, 0,0,0,0,0});
    add('{1,'h33,0,0,0,0,0,0,1,0,0,0,0, 1,'b011,0,0, 0,0,0,0,0});
    add('{0,0,0,0,0,0,0,'b011,1,0,0,0,0, 1,'b111,1,'h31, 0,0,0,0,0});
    add('{0,0,0,0,0,0,0,0,1,0,0,0,0, 1,'b000,0,0, 0,0,0,0,0});
    // forwarding on r5: pending P, known Q, kill Q, late result
    add('{1,'h41,1,5,0,0,0,0,1,0,0,5,7, 1,'b000,0,0, 0,0,0,0,0});
    add('{1,'h42,1,5,1,'hAA,0,0,1,0,0,5,7, 1,'b001,0,0, 1,1,0,0,0});
    add('{0,0,0,0,0,0,'b010,0,1,0,0,5,7, 0,'b011,0,0, 1,0,'hAA,0,0});
    add('{0,0,0,0,0,0,'b010,'b001,1,0,0,5,7, 1,'b011,0,0, 1,1,0,0,0});
    add('{0,0,0,0,0,0,0,0,1,1,'h55,5,7, 1,'b010,0,0, 1,0,'h55,0,0});
    add('{0,0,0,0,0,0,0,0,0,0,0,5,7, 1,'b100,1,'h41, 1,0,'h55,1,'h55});
    add('{0,0,0,0,0,0,0,0,1,0,0,0,0, 1,'b100,1,'h41, 0,0,0,1,'h55});
    add('{0,0,0,0,0,0,0,0,1,0,0,0,0, 1,'b000,0,0, 0,0,0,0,0});

    rst = 1'b1;
    drive('{default:0});
    #1;
    chk("rst in_ready", 32'(in_ready), 0);
    chk("rst out_valid", 32'(out_valid), 0);
    repeat (2) @(negedge clk);
    chk("rst stage_valid", 32'(stage_valid), 0);
    chk("rst in_ready2", 32'(in_ready), 0);
    rst = 1'b0;

    for (int n = 0; n < tbl.size(); n++) begin
      drive(tbl[n]);
      #1;
      check(tbl[n], n);
      @(negedge clk);
    end

    // r0 writer and r9 writer in flight, looked up on both ports
    in_valid = 1'b1; in_wen = 1'b1; in_waddr = 5'd0;
    in_wdv = 1'b1; in_wdata = 32'h77; in_data = 32'h51;
    out_ready = 1'b1; src_addr = '0;
    @(negedge clk);
    in_waddr = 5'd9; in_wdata = 32'h99; in_data = 32'h52;
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b0;
    src_addr = {5'd9, 5'd0};
    #1;
    chk("r0 fwd_hit", 32'(fwd_hit), 32'b10);
    chk("r0 fwd_data0", fwd_data[31:0], 0);
    chk("p1 fwd_data1", fwd_data[63:32], 32'h99);
    chk("p1 stage_valid", 32'(stage_valid), 32'b011);

    // reset mid-stream clears everything in one edge
    rst = 1'b1;
    #1;
    chk("mid rst in_ready", 32'(in_ready), 0);
    @(negedge clk);
    chk("mid rst stage_valid", 32'(stage_valid), 0);
    chk("mid rst out_valid", 32'(out_valid), 0);
    rst = 1'b0;
    #1;
    chk("post rst in_ready", 32'(in_ready), 1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             nchk, nfail);
    $finish;
  end

endmodule
